// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - fetch stage: PC, imem handshake, branch resolution, halt
module pc_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    input  logic [2:0]  flags,
    input  logic [15:0] rs_data,
    output logic        branch_taken,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetchState;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    fetchState   state;
    fetchState   nextState;
    logic [15:0] pcReg;
    logic [15:0] instrReg;
    logic [15:0] nextPc;
    logic [15:0] pcInc;
    logic [15:0] branchOffset;
    logic [3:0]  opCode;
    logic [2:0]  condCode;
    logic        flagZ;
    logic        flagV;
    logic        flagN;
    logic        condTrue;
    logic        isBranch;

    assign opCode       = instrReg[15:12];
    assign condCode     = instrReg[11:9];
    assign flagZ        = flags[2];
    assign flagV        = flags[1];
    assign flagN        = flags[0];
    assign pcInc        = pcReg + 16'd2;
    // 9-bit signed word offset scaled to bytes
    assign branchOffset = {{6{instrReg[8]}}, instrReg[8:0], 1'b0};
    assign isBranch     = (opCode == OP_B) || (opCode == OP_BR);

    assign imem_addr = pcReg;
    assign pc        = pcReg;
    assign pc_plus2  = pcInc;
    assign instr     = instrReg;

    // State register; reset aborts any in-flight fetch or PC update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Capture the fetched word and commit the next PC at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg    <= RESET_PC;
            instrReg <= 16'h0000;
        end else begin
            if (state == FETCH && imem_valid) begin
                instrReg <= imem_rdata;
            end
            if (state == EXEC) begin
                pcReg <= nextPc;
            end
        end
    end

    // Condition evaluation against {Z,V,N}
    always_comb begin
        condTrue = 1'b0;
        case (condCode)
            3'b000:  condTrue = !flagZ;
            3'b001:  condTrue = flagZ;
            3'b010:  condTrue = !flagZ && !flagN;
            3'b011:  condTrue = flagN;
            3'b100:  condTrue = flagZ || (!flagZ && !flagN);
            3'b101:  condTrue = flagN || flagZ;
            3'b110:  condTrue = flagV;
            default: condTrue = 1'b1;
        endcase
    end

    // Next-PC selection by opcode; HLT keeps its own address
    always_comb begin
        nextPc = pcInc;
        case (opCode)
            OP_B:    nextPc = condTrue ? (pcInc + branchOffset) : pcInc;
            OP_BR:   nextPc = condTrue ? rs_data : pcInc;
            OP_HLT:  nextPc = pcReg;
            default: nextPc = pcInc;
        endcase
    end

    // Next-state and per-state outputs
    always_comb begin
        nextState    = state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        branch_taken = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                instr_valid  = 1'b1;
                branch_taken = isBranch && condTrue;
                nextState    = (opCode == OP_HLT) ? HALT : FETCH;
            end
            HALT: begin
                halted    = 1'b1;
                nextState = HALT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed vector bench for pc_fetch
`timescale 1ns/1ps
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [2:0]  flags;
    logic [15:0] rs_data;
    logic        branch_taken;
    logic        halted;

    int nCompared;
    int nMismatched;

    pc_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .flags       (flags),
        .rs_data     (rs_data),
        .branch_taken(branch_taken),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic [2:0]  flg;
        logic [15:0] rs;
        int          waitCyc;
        logic        expTaken;
        logic [15:0] expNext;
    } vecT;

    vecT vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, seen on a falling edge
    task automatic waitReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // Serve one fetch, check the EXEC cycle and (for non-HLT) the following fetch address
    task automatic runInstr(input logic [15:0] addr, input logic [15:0] word, input logic [2:0] flg,
                            input logic [15:0] rs, input int waitCyc, input logic expTaken,
                            input logic [15:0] expNext);
        bit ok;
        waitReq(ok);
        if (!ok) return;
        check("fetch_addr", {16'd0, imem_addr}, {16'd0, addr});
        check("fetch_no_exec", {31'd0, instr_valid}, 32'd0);
        for (int w = 0; w < waitCyc; w++) begin
            @(negedge clk);
            check("wait_req_held", {31'd0, imem_req}, 32'd1);
            check("wait_no_exec", {31'd0, instr_valid}, 32'd0);
        end
        imem_rdata = word;
        imem_valid = 1'b1;
        flags      = flg;
        rs_data    = rs;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_req_low", {31'd0, imem_req}, 32'd0);
        check("exec_instr", {16'd0, instr}, {16'd0, word});
        check("exec_pc", {16'd0, pc}, {16'd0, addr});
        check("exec_pc_plus2", {16'd0, pc_plus2}, {16'd0, addr + 16'd2});
        check("exec_taken", {31'd0, branch_taken}, {31'd0, expTaken});
        if (word[15:12] != 4'hF) begin
            @(negedge clk);
            check("next_req", {31'd0, imem_req}, 32'd1);
            check("next_valid_low", {31'd0, instr_valid}, 32'd0);
            check("next_pc", {16'd0, pc}, {16'd0, expNext});
        end
    endtask

    // Reference condition table, flags = {Z,V,N}
    function automatic logic refCond(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            3'd0: return ~z;
            3'd1: return z;
            3'd2: return ~z & ~n;
            3'd3: return n;
            3'd4: return z | ~n;
            3'd5: return n | z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic [15:0] curPc;
        logic [15:0] word;
        logic        tk;
        logic [15:0] tgt;
        bit          ok;

        nCompared   = 0;
        nMismatched = 0;

        //           addr      word      flg     rs        wait taken next
        vecs[0]  = '{16'h0000, 16'h1000, 3'b000, 16'h0000, 0, 1'b0, 16'h0002};
        vecs[1]  = '{16'h0002, 16'hD400, 3'b000, 16'h0010, 0, 1'b1, 16'h0010};
        vecs[2]  = '{16'h0010, 16'hC1FE, 3'b000, 16'h0000, 0, 1'b1, 16'h000E};
        vecs[3]  = '{16'h000E, 16'hDE00, 3'b111, 16'h0010, 0, 1'b1, 16'h0010};
        vecs[4]  = '{16'h0010, 16'hC1FE, 3'b100, 16'h0000, 0, 1'b0, 16'h0012};
        vecs[5]  = '{16'h0012, 16'hC0FE, 3'b000, 16'h0000, 1, 1'b1, 16'h0210};
        vecs[6]  = '{16'h0210, 16'hCE00, 3'b010, 16'h0000, 0, 1'b1, 16'h0212};
        vecs[7]  = '{16'h0212, 16'hC0FF, 3'b100, 16'h0000, 0, 1'b0, 16'h0214};
        vecs[8]  = '{16'h0214, 16'hC0FF, 3'b001, 16'h0000, 0, 1'b1, 16'h0414};
        vecs[9]  = '{16'h0414, 16'hDE00, 3'b000, 16'hFFFE, 0, 1'b1, 16'hFFFE};
        vecs[10] = '{16'hFFFE, 16'h1000, 3'b000, 16'h0000, 0, 1'b0, 16'h0000};
        vecs[11] = '{16'h0000, 16'hC3FF, 3'b100, 16'h0000, 0, 1'b1, 16'h0000};
        vecs[12] = '{16'h0000, 16'hDE00, 3'b000, 16'h1235, 3, 1'b1, 16'h1235};

        rst_n      = 1'b0;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        flags      = 3'b000;
        rs_data    = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_pc", {16'd0, pc}, 32'h0000);
        check("rst_instr", {16'd0, instr}, 32'h0000);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_taken", {31'd0, branch_taken}, 32'd0);

        rst_n = 1'b1;
        #1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", {16'd0, imem_addr}, 32'h0000);
        @(posedge clk);
        #1;

        // Table-driven directed vectors; the first request is already pending
        for (int i = 0; i < 13; i++) begin
            runInstr(vecs[i].addr, vecs[i].word, vecs[i].flg, vecs[i].rs, vecs[i].waitCyc,
                     vecs[i].expTaken, vecs[i].expNext);
        end

        // Condition sweep: BR and B over every ccc/flag pair
        curPc = 16'h1235;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                tk = refCond(c[2:0], f[2:0]);
                if (f[0]) begin
                    word = {4'hD, c[2:0], 9'h000};
                    tgt  = 16'h4000 + 16'(c * 16 + f * 2);
                    runInstr(curPc, word, f[2:0], tgt, 0, tk, tk ? tgt : curPc + 16'd2);
                    curPc = tk ? tgt : curPc + 16'd2;
                end else begin
                    word = {4'hC, c[2:0], 9'h004};
                    runInstr(curPc, word, f[2:0], 16'hBEEF, 0, tk,
                             tk ? curPc + 16'd10 : curPc + 16'd2);
                    curPc = tk ? curPc + 16'd10 : curPc + 16'd2;
                end
            end
        end

        // Halt: pc held, no requests even with valid toggling
        runInstr(curPc, 16'hF000, 3'b111, 16'h0000, 0, 1'b0, curPc);
        for (int k = 0; k < 4; k++) begin
            imem_valid = k[0];
            imem_rdata = 16'h1000;
            @(negedge clk);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_pc", {16'd0, pc}, {16'd0, curPc});
        end
        imem_valid = 1'b0;

        // Async reset during HALT clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("hrst_halted", {31'd0, halted}, 32'd0);
        check("hrst_pc", {16'd0, pc}, 32'h0000);
        check("hrst_instr", {16'd0, instr}, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        runInstr(16'h0000, 16'h1000, 3'b000, 16'h0000, 0, 1'b0, 16'h0002);

        // Async reset during a FETCH wait aborts the access
        waitReq(ok);
        check("fwait_addr", {16'd0, imem_addr}, 32'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        check("frst_req", {31'd0, imem_req}, 32'd0);
        check("frst_pc", {16'd0, pc}, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("frst_idle", {31'd0, imem_req}, 32'd0);
        runInstr(16'h0000, 16'h2000, 3'b000, 16'h0000, 0, 1'b0, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
